// File: rtl/song_reader_pkg.sv
// Shared definitions for the song sequencer: entry widths, FSM states and the end marker.
package song_pkg;
  localparam int NOTE_W  = 6;
  localparam int DUR_W   = 6;
  localparam int ENTRY_W = NOTE_W + DUR_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LAT  = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic [ENTRY_W-1:0] END_MARKER = '0;
endpackage

// File: rtl/song_reader_rom.sv
// Synchronous song ROM: {note, duration} entries addressed by {song, index}, one-cycle read latency.
module song_rom
  import song_pkg::*;
#(
  parameter int NUM_SONGS      = 4,
  parameter int NOTES_PER_SONG = 32,
  localparam int SW = $clog2(NUM_SONGS),
  localparam int IW = $clog2(NOTES_PER_SONG)
) (
  input  logic               clk,
  input  logic [SW+IW-1:0]   addr,
  output logic [ENTRY_W-1:0] dout
);

  function automatic logic [ENTRY_W-1:0] entry(input logic [SW+IW-1:0] a);
    logic [SW-1:0] s;
    logic [IW-1:0] i;
    {s, i} = a;
    entry = END_MARKER;
    case (int'(s))
      0: begin
        if (int'(i) == 0)      entry = {NOTE_W'(20), DUR_W'(4)};
        else if (int'(i) == 1) entry = {NOTE_W'(22), DUR_W'(8)};
      end
      // every slot is populated, so this song only ends by running out of slots
      1: entry = {NOTE_W'(int'(i) + 1), DUR_W'(int'(i) + 10)};
      2: begin
        if (int'(i) == 0)      entry = {NOTE_W'(30), DUR_W'(12)};
        else if (int'(i) == 1) entry = {NOTE_W'(31), DUR_W'(6)};
        else if (int'(i) == 2) entry = {NOTE_W'(33), DUR_W'(3)};
      end
      3: begin
        if (int'(i) < 5) entry = {NOTE_W'(40 + int'(i)), DUR_W'(5)};
      end
      default: entry = END_MARKER;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    dout <= entry(addr);
  end

endmodule

// File: rtl/song_reader.sv
// Song sequencer: fetches {note, duration} pairs from the song ROM and strobes each one
// into note_player, waiting for a fresh done level before moving to the next entry.
module song_reader
  import song_pkg::*;
#(
  parameter int NUM_SONGS      = 4,
  parameter int NOTES_PER_SONG = 32,
  localparam int SW = $clog2(NUM_SONGS),
  localparam int IW = $clog2(NOTES_PER_SONG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic [SW-1:0]     song,
  input  logic              note_done,
  output logic [NOTE_W-1:0] note_to_load,
  output logic [DUR_W-1:0]  duration_to_load,
  output logic              load_new_note,
  output logic              song_done
);

  state_e             state;
  logic [IW-1:0]      index;
  logic [SW-1:0]      song_latched;
  logic               arm;
  logic               done_seen;
  logic [ENTRY_W-1:0] rom_data_p1;
  logic               note_finished;

  song_rom #(
    .NUM_SONGS     (NUM_SONGS),
    .NOTES_PER_SONG(NOTES_PER_SONG)
  ) u_rom (
    .clk (clk),
    .addr({song_latched, index}),
    .dout(rom_data_p1)
  );

  // A done rise counts only after a low has been seen; done_seen keeps a rise that happened during a pause.
  assign note_finished = done_seen | (arm & note_done);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      index            <= '0;
      song_latched     <= '0;
      arm              <= 1'b0;
      done_seen        <= 1'b0;
      note_to_load     <= '0;
      duration_to_load <= '0;
      load_new_note    <= 1'b0;
      song_done        <= 1'b0;
    end else begin
      load_new_note <= 1'b0;
      case (state)
        IDLE: begin
          if (play) begin
            song_latched <= song;
            index        <= '0;
            state        <= RD;
          end
        end
        RD: begin
          if (play) state <= LAT;
        end
        LAT: begin
          if (play) begin
            if (rom_data_p1 == END_MARKER) begin
              song_done <= 1'b1;
              state     <= DONE;
            end else begin
              {note_to_load, duration_to_load} <= rom_data_p1;
              load_new_note <= 1'b1;
              arm           <= 1'b0;
              done_seen     <= 1'b0;
              state         <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!note_done) arm <= 1'b1;
          if (arm && note_done) done_seen <= 1'b1;
          if (play && note_finished) begin
            if (index == IW'(NOTES_PER_SONG - 1)) begin
              song_done <= 1'b1;
              state     <= DONE;
            end else begin
              index <= index + 1'b1;
              state <= RD;
            end
          end
        end
        DONE: begin
          if (!play) begin
            song_done <= 1'b0;
            index     <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: scenario tasks plus randomized songs checked against a table-driven song model.
module tb_song_reader;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       play = 1'b0;
  logic [1:0] song = 2'd0;
  logic       note_done = 1'b0;
  logic [5:0] note_to_load;
  logic [5:0] duration_to_load;
  logic       load_new_note;
  logic       song_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [11:0] rom_model [4][32];

  song_reader dut (
    .clk             (clk),
    .reset           (reset),
    .play            (play),
    .song            (song),
    .note_done       (note_done),
    .note_to_load    (note_to_load),
    .duration_to_load(duration_to_load),
    .load_new_note   (load_new_note),
    .song_done       (song_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; play = 1'b0; note_done = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_strobe(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (load_new_note) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  function automatic int song_len(input int s);
    int n = 0;
    while (n < 32 && rom_model[s][n] != 12'd0) n++;
    return n;
  endfunction

  task automatic build_model();
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 32; i++) rom_model[s][i] = 12'd0;
    rom_model[0][0] = {6'd20, 6'd4};
    rom_model[0][1] = {6'd22, 6'd8};
    for (int i = 0; i < 32; i++) rom_model[1][i] = {6'(i + 1), 6'(i + 10)};
    rom_model[2][0] = {6'd30, 6'd12};
    rom_model[2][1] = {6'd31, 6'd6};
    rom_model[2][2] = {6'd33, 6'd3};
    for (int i = 0; i < 5; i++) rom_model[3][i] = {6'(40 + i), 6'd5};
  endtask

  task automatic test_reset();
    reset = 1'b0; play = 1'b0;
    tick(); tick();
    total++; if (note_to_load !== 6'd0) begin bad++; $display("FAIL reset_note got=%0d want=0", note_to_load); end
    total++; if (duration_to_load !== 6'd0) begin bad++; $display("FAIL reset_dur got=%0d want=0", duration_to_load); end
    total++; if (load_new_note !== 1'b0) begin bad++; $display("FAIL reset_load got=%b want=0", load_new_note); end
    total++; if (song_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", song_done); end
    reset = 1'b1;
  endtask

  task automatic test_song0();
    bit got;
    int c, d, extra;
    do_reset();
    song = 2'd0; play = 1'b1; c = cyc;
    wait_strobe(10, got);
    total++; if (!got || cyc != c + 3) begin bad++; $display("FAIL s0_first_latency got=%0d want=%0d", cyc - c, 3); end
    total++; if ({note_to_load, duration_to_load} !== {6'd20, 6'd4}) begin
      bad++; $display("FAIL s0_entry0 got=%0d/%0d want=20/4", note_to_load, duration_to_load); end
    note_done = 1'b0; tick(); note_done = 1'b1; d = cyc;
    wait_strobe(10, got);
    total++; if (!got || cyc != d + 3) begin bad++; $display("FAIL s0_next_latency got=%0d want=%0d", cyc - d, 3); end
    total++; if ({note_to_load, duration_to_load} !== {6'd22, 6'd8}) begin
      bad++; $display("FAIL s0_entry1 got=%0d/%0d want=22/8", note_to_load, duration_to_load); end
    note_done = 1'b0; tick(); note_done = 1'b1;
    extra = 0; got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (load_new_note) extra++;
      if (song_done) got = 1'b1;
    end
    total++; if (!got || extra != 0) begin bad++; $display("FAIL s0_end got=done:%0b extra:%0d want=done:1 extra:0", got, extra); end
  endtask

  task automatic test_done_restart();
    bit got;
    int c;
    play = 1'b0; tick();
    total++; if (song_done !== 1'b0) begin bad++; $display("FAIL rewind_clear got=%b want=0", song_done); end
    song = 2'd2; play = 1'b1; c = cyc;
    tick();
    song = 2'd3;
    wait_strobe(10, got);
    total++; if (!got || cyc != c + 3) begin bad++; $display("FAIL restart_latency got=%0d want=%0d", cyc - c, 3); end
    total++; if ({note_to_load, duration_to_load} !== rom_model[2][0]) begin
      bad++; $display("FAIL restart_song2 got=%0d/%0d want=30/12", note_to_load, duration_to_load); end
  endtask

  task automatic test_stale_done();
    bit got;
    int d, extra;
    do_reset();
    song = 2'd3; note_done = 1'b1; play = 1'b1;
    wait_strobe(10, got);
    total++; if (!got || {note_to_load, duration_to_load} !== rom_model[3][0]) begin
      bad++; $display("FAIL stale_first got=%0d/%0d want=40/5", note_to_load, duration_to_load); end
    extra = 0;
    repeat (8) begin tick(); if (load_new_note) extra++; end
    total++; if (extra != 0) begin bad++; $display("FAIL stale_hold got=%0d strobes want=0", extra); end
    note_done = 1'b0; tick(); note_done = 1'b1; d = cyc;
    wait_strobe(10, got);
    total++; if (!got || cyc != d + 3 || {note_to_load, duration_to_load} !== rom_model[3][1]) begin
      bad++; $display("FAIL stale_advance got=%0d/%0d at +%0d want=41/5 at +3", note_to_load, duration_to_load, cyc - d); end
  endtask

  task automatic test_pause();
    bit got;
    int r, extra;
    do_reset();
    song = 2'd1; play = 1'b1;
    wait_strobe(10, got);
    total++; if (!got || {note_to_load, duration_to_load} !== rom_model[1][0]) begin
      bad++; $display("FAIL pause_first got=%0d/%0d want=1/10", note_to_load, duration_to_load); end
    note_done = 1'b0; tick();
    play = 1'b0; extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (load_new_note) extra++;
      if (i == 3) note_done = 1'b1;
      if (i == 4) note_done = 1'b0;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL pause_quiet got=%0d strobes want=0", extra); end
    play = 1'b1; r = cyc;
    wait_strobe(10, got);
    total++; if (!got || cyc != r + 3) begin bad++; $display("FAIL pause_resume_latency got=%0d want=3", cyc - r); end
    total++; if ({note_to_load, duration_to_load} !== rom_model[1][1]) begin
      bad++; $display("FAIL pause_resume_entry got=%0d/%0d want=2/11", note_to_load, duration_to_load); end
  endtask

  task automatic test_full_song();
    bit got;
    int errs, extra;
    logic done_before;
    do_reset();
    song = 2'd1; play = 1'b1; errs = 0; done_before = 1'b0;
    for (int i = 0; i < 32; i++) begin
      wait_strobe(12, got);
      total++; if (!got || {note_to_load, duration_to_load} !== rom_model[1][i]) begin
        bad++; errs++;
        if (errs < 4) $display("FAIL full_entry%0d got=%0d/%0d strobe=%0b want=%0d/%0d", i, note_to_load,
                               duration_to_load, got, rom_model[1][i][11:6], rom_model[1][i][5:0]);
      end
      note_done = 1'b0; tick(); note_done = 1'b1;
      if (i == 31) done_before = song_done;
    end
    tick();
    total++; if (done_before !== 1'b0 || song_done !== 1'b1) begin
      bad++; $display("FAIL full_done got=%b->%b want=0->1", done_before, song_done); end
    extra = 0;
    repeat (8) begin tick(); if (load_new_note) extra++; end
    total++; if (extra != 0 || song_done !== 1'b1) begin
      bad++; $display("FAIL full_no_wrap got=%0d strobes done=%b want=0 strobes done=1", extra, song_done); end
  endtask

  task automatic test_reset_mid_wait();
    bit got;
    int c;
    do_reset();
    song = 2'd3; play = 1'b1;
    wait_strobe(10, got);
    note_done = 1'b0; tick();
    reset = 1'b0; tick();
    total++; if ({note_to_load, duration_to_load, load_new_note, song_done} !== 14'd0) begin
      bad++; $display("FAIL midwait_reset got=%0d/%0d/%b/%b want=0/0/0/0", note_to_load, duration_to_load,
                      load_new_note, song_done); end
    reset = 1'b1; c = cyc;
    wait_strobe(10, got);
    total++; if (!got || cyc != c + 3 || {note_to_load, duration_to_load} !== rom_model[3][0]) begin
      bad++; $display("FAIL midwait_restart got=%0d/%0d at +%0d want=40/5 at +3", note_to_load, duration_to_load, cyc - c); end
  endtask

  task automatic test_random();
    bit got;
    int s, n, extra;
    for (int iter = 0; iter < 6; iter++) begin
      do_reset();
      s = int'($urandom_range(3, 0));
      n = song_len(s);
      song = 2'(s); play = 1'b1;
      for (int i = 0; i < n; i++) begin
        wait_strobe(40, got);
        total++; if (!got || {note_to_load, duration_to_load} !== rom_model[s][i]) begin
          bad++; $display("FAIL rand_s%0d_e%0d got=%0d/%0d strobe=%0b want=%0d/%0d", s, i, note_to_load,
                          duration_to_load, got, rom_model[s][i][11:6], rom_model[s][i][5:0]);
          break;
        end
        note_done = 1'b0; tick();
        repeat ($urandom_range(3, 0)) tick();
        if ($urandom_range(1, 0) == 1) begin
          play = 1'b0;
          repeat ($urandom_range(4, 1)) tick();
          note_done = 1'b1; tick();
          if ($urandom_range(1, 0) == 1) note_done = 1'b0;
          repeat ($urandom_range(4, 1)) tick();
          play = 1'b1;
        end else begin
          note_done = 1'b1;
        end
      end
      extra = 0; got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        tick();
        if (load_new_note) extra++;
        if (song_done) got = 1'b1;
      end
      total++; if (!got || extra != 0) begin
        bad++; $display("FAIL rand_s%0d_end got=done:%0b extra:%0d want=done:1 extra:0", s, got, extra); end
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_song0();
    test_done_restart();
    test_stale_done();
    test_pause();
    test_full_song();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
